// File: rtl/led_pattern_sequencer_if.sv
// Control and status bundle for the LED pattern sequencer.
// The master drives enable and mode; the slave returns the LED pattern and the step pulse.
interface led_pattern_sequencer_if #(
  parameter int unsigned OUTPUT_WIDTH = 4
);
  logic                    enable;
  logic [1:0]              mode;
  logic [OUTPUT_WIDTH-1:0] out;
  logic                    step_tick;

  modport master (output enable, mode, input out, step_tick);
  modport slave  (input enable, mode, output out, step_tick);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Multi-mode LED pattern generator: a prescaler produces periodic steps, and on each step
// the registered pattern advances as a bar fill, a bouncing dot, a binary count or a blink.
module led_pattern_sequencer #(
  parameter int unsigned OUTPUT_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned MAX_COUNT    = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  led_pattern_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [COUNT_WIDTH-1:0]  CNT_TERM = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [OUTPUT_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [OUTPUT_WIDTH-1:0] ONE      = OUTPUT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0]  cnt_q,  cnt_d;
  logic [OUTPUT_WIDTH-1:0] out_q,  out_d;
  logic                    tick_q, tick_d;
  dir_e                    dir_q,  dir_d;
  mode_e                   mode_q, mode_d;

  mode_e                   mode_in;
  logic                    step;
  logic [OUTPUT_WIDTH-1:0] shl0, shl1, shr0;

  assign mode_in = mode_e'(bus.mode);
  assign step    = bus.enable && (cnt_q == CNT_TERM);
  assign shl0    = {out_q[OUTPUT_WIDTH-2:0], 1'b0};
  assign shl1    = {out_q[OUTPUT_WIDTH-2:0], 1'b1};
  assign shr0    = {1'b0, out_q[OUTPUT_WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= '0;
      tick_q <= 1'b0;
      dir_q  <= DIR_UP;
      mode_q <= MODE_FILL;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    dir_d  = dir_q;
    mode_d = mode_q;

    if (bus.enable) begin
      if (!step) begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end else begin
        cnt_d  = '0;
        tick_d = 1'b1;
        // A pending mode change consumes the step: load the start value instead of advancing.
        if (mode_in != mode_q) begin
          mode_d = mode_in;
          dir_d  = DIR_UP;
          out_d  = (mode_in == MODE_BOUNCE) ? ONE : '0;
        end else begin
          unique case (mode_q)
            MODE_FILL: begin
              if (dir_q == DIR_UP) begin
                out_d = shl1;
                if (shl1 == ALL_ONES) dir_d = DIR_DOWN;
              end else begin
                out_d = shr0;
                if (shr0 == '0) dir_d = DIR_UP;
              end
            end
            MODE_BOUNCE: begin
              if (dir_q == DIR_UP) begin
                out_d = shl0;
                if (shl0[OUTPUT_WIDTH-1]) dir_d = DIR_DOWN;
              end else begin
                out_d = shr0;
                if (shr0 == ONE) dir_d = DIR_UP;
              end
            end
            MODE_COUNT: out_d = out_q + ONE;
            MODE_BLINK: out_d = ~out_q;
            default:    out_d = out_q;
          endcase
        end
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: two instances (MAX_COUNT=2 and MAX_COUNT=0) share stimulus
// and are compared every cycle against a phase-index reference model of the four patterns.
module tb_led_pattern_sequencer;

  localparam int W = 4;

  typedef struct {
    int cnt;
    int mode;
    int phase;
    int tick;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_pattern_sequencer_if #(.OUTPUT_WIDTH(W)) ifa ();
  led_pattern_sequencer_if #(.OUTPUT_WIDTH(W)) ifb ();

  led_pattern_sequencer #(.OUTPUT_WIDTH(W), .COUNT_WIDTH(32), .MAX_COUNT(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  led_pattern_sequencer #(.OUTPUT_WIDTH(W), .COUNT_WIDTH(32), .MAX_COUNT(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  model_t ma, mb;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_of(input int mode);
    case (mode)
      0:       return 2 * W;
      1:       return 2 * W - 2;
      2:       return 1 << W;
      default: return 2;
    endcase
  endfunction

  // Pattern value as a closed-form function of the step index within the current mode.
  function automatic int pattern_of(input model_t m);
    int k;
    case (m.mode)
      0: begin
        k = (m.phase <= W) ? m.phase : 2 * W - m.phase;
        return (1 << k) - 1;
      end
      1: begin
        k = (m.phase <= W - 1) ? m.phase : 2 * W - 2 - m.phase;
        return 1 << k;
      end
      2:       return m.phase;
      default: return (m.phase % 2 == 1) ? (1 << W) - 1 : 0;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.cnt = 0; m.mode = 0; m.phase = 0; m.tick = 0;
    return m;
  endfunction

  function automatic model_t model_next(input model_t m, input int en, input int md, input int maxc);
    model_t n = m;
    n.tick = 0;
    if (en != 0) begin
      if (m.cnt == maxc) begin
        n.cnt  = 0;
        n.tick = 1;
        if (md != m.mode) begin
          n.mode  = md;
          n.phase = 0;
        end else begin
          n.phase = (m.phase + 1) % period_of(m.mode);
        end
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    return n;
  endfunction

  task automatic drive(input int en, input int md);
    ifa.enable = en[0];  ifa.mode = md[1:0];
    ifb.enable = en[0];  ifb.mode = md[1:0];
  endtask

  task automatic cycle(input string tag);
    ma = model_next(ma, int'(ifa.enable), int'(ifa.mode), 2);
    mb = model_next(mb, int'(ifb.enable), int'(ifb.mode), 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_a_out"},  int'(ifa.out),       pattern_of(ma));
    check_eq({tag, "_a_tick"}, int'(ifa.step_tick), ma.tick);
    check_eq({tag, "_b_out"},  int'(ifb.out),       pattern_of(mb));
    check_eq({tag, "_b_tick"}, int'(ifb.step_tick), mb.tick);
  endtask

  task automatic run(input string tag, input int n, input int en, input int md);
    drive(en, md);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Reset is asserted and released between clock edges; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq({tag, "_rst_a_out"},  int'(ifa.out),       0);
    check_eq({tag, "_rst_a_tick"}, int'(ifa.step_tick), 0);
    check_eq({tag, "_rst_b_out"},  int'(ifb.out),       0);
    check_eq({tag, "_rst_b_tick"}, int'(ifb.step_tick), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    ma = model_reset();
    mb = model_reset();
  endtask

  initial begin
    int en, md, steps_seen;
    drive(0, 0);
    ma = model_reset();
    mb = model_reset();

    do_reset("init");
    run("fill", 27, 1, 0);

    do_reset("bounce");
    run("bounce", 24, 1, 1);
    run("blink", 12, 1, 3);

    run("count", 3 * 18, 1, 2);

    do_reset("fill2cnt");
    run("fill_pre", 16, 1, 0);
    run("fill2cnt", 6, 1, 2);

    do_reset("freeze");
    run("frz_pre", 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, i % 4);
      cycle("frz");
    end
    drive(1, 0);
    cycle("frz_res1");
    cycle("frz_res2");
    check_eq("frz_step_after_2", int'(ifa.step_tick), 1);

    // Freeze exactly at terminal count: step must fire on the first re-enabled cycle.
    run("term_pre", 2, 1, 0);
    run("term_hold", 4, 0, 0);
    drive(1, 0);
    cycle("term_res");
    check_eq("term_step_first", int'(ifa.step_tick), 1);

    steps_seen = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rnd");
      end
      en = ($urandom_range(0, 4) != 0) ? 1 : 0;
      md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'(ifa.mode);
      drive(en, md);
      cycle("rnd");
      if (ifa.step_tick) steps_seen++;
    end
    check_eq("rnd_steps_nonzero", (steps_seen > 0) ? 1 : 0, 1);

    do_reset("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
